// File: rtl/rsa_pkg.sv
// Shared constants for the RSA decrypt block: command codes, FSM encoding and default key.
package rsa_pkg;

    localparam int unsigned RSA_W         = 13;
    localparam int unsigned RSA_N_DEFAULT = 3233;
    localparam int unsigned RSA_D_DEFAULT = 2753;
    localparam int unsigned DATA_W        = 13;
    localparam int unsigned IO_W          = 16;

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_CIPHER = 3'd1;
    localparam logic [2:0] CMD_N      = 3'd2;
    localparam logic [2:0] CMD_D      = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REDUCE = 3'd1,
        S_MUL    = 3'd2,
        S_SQR    = 3'd3,
        S_DONE   = 3'd4,
        S_ARM    = 3'd5
    } state_e;

endpackage

// File: rtl/rsa_modmul.sv
// Bit-serial MSB-first interleaved modular multiplier: result = a*b mod n in W cycles.
module rsa_modmul #(
    parameter int unsigned W = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic [W-1:0] result,
    output logic         done
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  r_q, r_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  n_q, n_d;
    logic [W-1:0]  res_q, res_d;

    // One interleaved step; r and addend are < m, so the W+1 bit sum never overflows.
    function automatic logic [W-1:0] step(input logic [W-1:0] r, input logic [W-1:0] addend,
                                          input logic bit_i, input logic [W-1:0] m);
        logic [W:0] t;
        t = {r, 1'b0};
        if (t >= {1'b0, m}) t = t - {1'b0, m};
        if (bit_i)          t = t + {1'b0, addend};
        if (t >= {1'b0, m}) t = t - {1'b0, m};
        return t[W-1:0];
    endfunction

    // The start cycle already consumes the top multiplier bit, giving W cycles start-to-done.
    always_comb begin
        busy_d = busy_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        r_d    = r_q;
        a_d    = a_q;
        b_d    = b_q;
        n_d    = n_q;
        res_d  = res_q;
        if (busy_q) begin
            r_d = step(r_q, a_q, b_q[cnt_q], n_q);
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                res_d  = r_d;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end else if (start) begin
            a_d    = a;
            b_d    = b;
            n_d    = n;
            r_d    = step('0, a, b[W-1], n);
            cnt_d  = CW'(W - 2);
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            r_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            res_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            r_q    <= r_d;
            a_q    <= a_d;
            b_q    <= b_d;
            n_q    <= n_d;
            res_q  <= res_d;
        end
    end

    assign result = res_q;
    assign done   = done_q;

endmodule

// File: rtl/rsa_decrypt.sv
// RSA decryption m = c^d mod n by right-to-left square-and-multiply over a serial modmul unit.
module rsa_decrypt import rsa_pkg::*; #(
    parameter int unsigned W         = RSA_W,
    parameter int unsigned N_DEFAULT = RSA_N_DEFAULT,
    parameter int unsigned D_DEFAULT = RSA_D_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IO_W-1:0] io_in,
    output logic [IO_W-1:0] io_out
);

    state_e       state_q, state_d;
    logic [2:0]   cmd;
    logic [W-1:0] data;
    logic [W-1:0] n_q, n_d, d_q, d_d, c_q, c_d;
    logic [W-1:0] res_q, res_d, base_q, base_d, exp_q, exp_d, pt_q, pt_d;
    logic         valid_q, valid_d, busy_q, busy_d;
    logic         launch;
    logic         mm_start_c;
    logic [W-1:0] mm_a_c, mm_b_c, mm_result;
    logic         mm_done;

    assign cmd  = io_in[IO_W-1:DATA_W];
    assign data = W'(io_in[DATA_W-1:0]);

    function automatic state_e next_op(input logic [W-1:0] e);
        if (e == '0) return S_DONE;
        return e[0] ? S_MUL : S_SQR;
    endfunction

    // Next state; a new modmul is launched in the same cycle the previous one finishes.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        c_d     = c_q;
        res_d   = res_q;
        base_d  = base_q;
        exp_d   = exp_q;
        pt_d    = pt_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        launch  = 1'b0;
        mm_a_c  = '0;
        mm_b_c  = '0;
        case (state_q)
            S_IDLE: begin
                case (cmd)
                    CMD_CIPHER: begin
                        c_d     = data;
                        res_d   = W'(1);
                        exp_d   = d_q;
                        valid_d = 1'b0;
                        busy_d  = 1'b1;
                        if (n_q < W'(2)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_REDUCE;
                            launch  = 1'b1;
                        end
                    end
                    CMD_N: begin
                        n_d     = data;
                        state_d = S_ARM;
                    end
                    CMD_D: begin
                        d_d     = data;
                        state_d = S_ARM;
                    end
                    default: ;
                endcase
            end
            S_REDUCE: begin
                if (mm_done) begin
                    base_d  = mm_result;
                    state_d = next_op(exp_q);
                    launch  = (state_d != S_DONE);
                end
            end
            S_MUL: begin
                if (mm_done) begin
                    res_d = mm_result;
                    if ((exp_q >> 1) == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SQR;
                        launch  = 1'b1;
                    end
                end
            end
            S_SQR: begin
                if (mm_done) begin
                    base_d  = mm_result;
                    exp_d   = exp_q >> 1;
                    state_d = next_op(exp_d);
                    launch  = (state_d != S_DONE);
                end
            end
            S_DONE: begin
                pt_d    = (n_q < W'(2)) ? '0 : res_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_ARM;
            end
            S_ARM: begin
                if (cmd == CMD_NONE || cmd[2]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // REDUCE uses multiplier c against a=1, so c >= n is folded by the Horner steps.
        if (launch) begin
            case (state_d)
                S_REDUCE: begin mm_a_c = W'(1); mm_b_c = c_d;    end
                S_MUL:    begin mm_a_c = res_d; mm_b_c = base_d; end
                default:  begin mm_a_c = base_d; mm_b_c = base_d; end
            endcase
        end
    end

    assign mm_start_c = launch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_q     <= W'(N_DEFAULT);
            d_q     <= W'(D_DEFAULT);
            c_q     <= '0;
            res_q   <= '0;
            base_q  <= '0;
            exp_q   <= '0;
            pt_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            c_q     <= c_d;
            res_q   <= res_d;
            base_q  <= base_d;
            exp_q   <= exp_d;
            pt_q    <= pt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    rsa_modmul #(.W(W)) u_modmul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mm_start_c),
        .a      (mm_a_c),
        .b      (mm_b_c),
        .n      (n_q),
        .result (mm_result),
        .done   (mm_done)
    );

    assign io_out = {1'b0, valid_q, busy_q, DATA_W'(pt_q)};

endmodule

// File: tb/tb_rsa_decrypt.sv
// Scoreboard bench for rsa_decrypt: stimulus queues expected plaintexts, a monitor checks each valid.
module tb_rsa_decrypt;
    import rsa_pkg::*;

    localparam int BOUND = 4 + 13 * (1 + 2 * 13);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] io_in;
    logic [15:0] io_out;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    logic prev_v = 1'b0;
    int   mon_e;

    always #5 clk = ~clk;

    rsa_decrypt dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_in  (io_in),
        .io_out (io_out)
    );

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    function automatic longint modexp(input longint c, input longint e, input longint m);
        longint b, r;
        b = c % m;
        r = 1 % m;
        while (e > 0) begin
            if (e % 2 == 1) r = (r * b) % m;
            b = (b * b) % m;
            e = e / 2;
        end
        return r;
    endfunction

    // Monitor: every rising edge of valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && io_out[14] && !prev_v) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1'b0, io_out[12:0], -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("plaintext", io_out[12:0] == 13'(mon_e), io_out[12:0], mon_e);
                check("busy_at_valid", io_out[13] == 1'b0, io_out[13], 0);
                check("bit15_zero", io_out[15] == 1'b0, io_out[15], 0);
            end
        end
        prev_v = io_out[14];
    end

    task automatic send(input logic [2:0] cmd, input int data, input int hold);
        @(negedge clk);
        io_in = {cmd, 13'(data)};
        repeat (hold) @(negedge clk);
        io_in = 16'h0;
    endtask

    task automatic wait_valid(input int limit, output int lat);
        lat = 1;
        while (!io_out[14] && lat <= limit) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_cipher(input string name, input int data, input int expv, input int bound);
        int lat;
        exp_q.push_back(expv);
        send(CMD_CIPHER, data, 1);
        wait_valid(bound + 20, lat);
        check(name, io_out[14] && lat <= bound, lat, bound);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  quiet;
        longint golden;
        io_in = 16'h0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_io_out", io_out == 16'h0, io_out, 0);
        rst_n = 1'b1;

        // Default key: textbook pair.
        run_cipher("lat_default_2790", 2790, 65, BOUND);

        // Key loads while busy must be ignored.
        exp_q.push_back(65);
        send(CMD_CIPHER, 2790, 1);
        send(CMD_N, 77, 3);
        send(CMD_D, 37, 3);
        wait_valid(BOUND + 20, lat);
        check("busy_ignore_done", io_out[14], io_out[14], 1);
        run_cipher("lat_key_unchanged", 2790, 65, BOUND);

        // Cipher above the modulus.
        golden = modexp(8000, 2753, 3233);
        run_cipher("lat_c_ge_n", 8000, int'(golden), BOUND);

        // Reset in the middle of a squaring step.
        exp_q.push_back(65);
        send(CMD_CIPHER, 2790, 1);
        repeat (30) @(negedge clk);
        check("busy_before_reset", io_out[13], io_out[13], 1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_io_out", io_out == 16'h0, io_out, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (io_out != 16'h0) quiet = 1'b0;
        end
        check("quiet_after_reset", quiet, quiet, 1);
        run_cipher("lat_after_reset", 2790, 65, BOUND);

        // Held N_READY, then a small key.
        send(CMD_N, 77, 5);
        send(CMD_D, 37, 1);
        run_cipher("lat_n77_d37", 2, 51, BOUND);

        // Zero exponent.
        send(CMD_N, 3233, 1);
        send(CMD_D, 0, 1);
        run_cipher("lat_d0", 1234, 1, BOUND);

        // Degenerate modulus short-circuits.
        send(CMD_N, 1, 1);
        run_cipher("lat_n1", 5, 0, 2);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rsa_decrypt.md
RSA_DECRYPT -- requirements
Module: rsa_decrypt

Interface
REQ-001 SHALL have parameter W, default 13, giving the operand, modulus and exponent width in bits.
REQ-002 SHALL have parameter N_DEFAULT, default 3233, giving the modulus after reset.
REQ-003 SHALL have parameter D_DEFAULT, default 2753, giving the private exponent after reset.
REQ-004 SHALL have port clk, input, width 1: the single clock; all state SHALL be on its rising edge.
REQ-005 SHALL have port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-006 SHALL have port io_in, input, width 16: [12:0] is the data word; [15:13] is the command code (0 NONE, 1 CIPHER_READY, 2 N_READY, 3 D_READY, 4-7 reserved and treated as NONE).
REQ-007 SHALL have port io_out, output, width 16: [12:0] is plaintext; [13] is busy; [14] is valid; [15] is constant 0.

Function
REQ-008 SHALL implement states IDLE, REDUCE, MUL, SQR, DONE and ARM.
REQ-009 SHALL accept a command only in IDLE with a non-NONE code present; commands in any other state SHALL be ignored.
REQ-010 N_READY SHALL load n <= data in 1 cycle; D_READY SHALL load d <= data in 1 cycle; both SHALL then go to ARM.
REQ-011 CIPHER_READY SHALL latch c <= data, set result=1 and exp=d, clear valid, set busy the next cycle, and go to REDUCE.
REQ-012 ARM SHALL hold until the code is NONE, then return to IDLE; a held code SHALL never retrigger.
REQ-013 REDUCE SHALL compute base = (c*1) mod n on the modmul unit, so c >= n is legal.
REQ-014 After REDUCE: exp==0 SHALL go to DONE; otherwise exp[0]==1 SHALL go to MUL and exp[0]==0 SHALL go to SQR.
REQ-015 MUL SHALL compute result = result*base mod n; then, if exp>>1 == 0, SHALL go to DONE, else SQR.
REQ-016 SQR SHALL compute base = base*base mod n and exp >>= 1, then SHALL branch as REQ-014 on the new exp.
REQ-017 Each modmul SHALL take exactly 13 cycles from its start pulse to its done pulse.
REQ-018 The modmul algorithm SHALL be MSB-first interleaved: r = 0; for each multiplier bit i from 12 down to 0, r = 2r, subtract n if r >= n, add a if bit i is set, subtract n if r >= n.
REQ-019 Intermediate r SHALL be W+1 bits wide; operands SHALL be < n on entry (guaranteed by REDUCE).
REQ-020 Total latency from acceptance to valid SHALL be <= 4 + 13*(1 + 2*W) cycles.
REQ-021 DONE SHALL drive plaintext = result (0 if n == 1), set valid, clear busy, and go to ARM.
REQ-022 d == 0 SHALL yield plaintext 1 mod n.
REQ-023 n < 2 SHALL skip computation: DONE in the cycle after acceptance, plaintext = 0, valid = 1.
REQ-024 Plaintext and valid SHALL hold until the next accepted CIPHER_READY; N_READY and D_READY SHALL not clear valid.

Reset
REQ-025 rst_n low SHALL asynchronously force state = IDLE, n = N_DEFAULT, d = D_DEFAULT, io_out = 0 and clear the modmul unit.
REQ-026 A reset asserted mid-operation SHALL abandon it with no valid pulse; after release the block SHALL be in IDLE with no ARM wait.

Structure
REQ-027 Package rsa_pkg SHALL hold the command code constants, state encoding, W, N_DEFAULT and D_DEFAULT.
REQ-028 The multiply-modulo engine SHALL be sub-module rsa_modmul, with ports clk, rst_n, start, a, b, n, result, done; a start while busy SHALL be ignored.

Verification
REQ-029 Defaults, CIPHER_READY with data=2790 -> plaintext 65, valid=1, busy=0, within the REQ-020 bound.
REQ-030 N_READY 77 with code held 5 cycles, then NONE, D_READY 37, NONE, CIPHER_READY 2 -> plaintext 2^37 mod 77 = 51; the held code loads exactly once.
REQ-031 n=3233, D_READY 0, cipher 1234 -> plaintext 1; N_READY 1, cipher 5 -> plaintext 0 within 2 cycles.
REQ-032 Cipher 8000 (>= n=3233), d=2753 -> plaintext equals the golden model of (8000 mod 3233)^2753 mod 3233.
REQ-033 rst_n pulsed low during SQR -> io_out = 0 immediately, n=3233 and d=2753 restored; a new cipher 2790 -> 65.
REQ-034 N_READY or D_READY issued while busy -> ignored: n and d unchanged and the result is unaffected.
